// File: rtl/prefetch_pkg.sv
// Shared types for the next-line prefetcher: line-address type, FSM states
// and the line-address to byte-address helper.
package prefetch_pkg;

    localparam int LINE_BYTES = 32;
    localparam int S_OFFSET   = $clog2(LINE_BYTES);

    typedef logic [31-S_OFFSET:0] line_addr_t;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_FETCH,
        PF_HOLD
    } pf_state_t;

    function automatic logic [31:0] line_to_byte(input line_addr_t line);
        return {line, {S_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/pf_addr_fifo.sv
// Candidate line-address FIFO. A push while full is accepted only when a pop
// happens in the same cycle; otherwise the new entry is discarded.
module pf_addr_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  line_addr_t push_data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output line_addr_t head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    line_addr_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/next_line_prefetcher.sv
// Next-line prefetcher: demand miss -> candidate FIFO -> private memory fetch
// -> one-line buffer offered to the cache. Define PF_FILTER_EN for the recent-fetch filter.
module next_line_prefetcher
    import prefetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2,
    parameter int FILTER_SIZE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         demand_miss_valid,
    input  logic [31:0]  demand_miss_addr,
    output logic         pf_pmem_read,
    output logic [31:0]  pf_pmem_address,
    input  logic [255:0] pf_pmem_rdata,
    input  logic         pf_pmem_resp,
    output logic         prefetch_ready,
    output logic [31:0]  pf_cline_address,
    output logic [255:0] prefetch_rdata,
    input  logic         pf_ack,
    input  logic         pf_drop,
    output pf_state_t    dbg_state_o
);

    // Handshake: pf_pmem_read stays high with a stable address until the single-cycle
    // pf_pmem_resp; prefetch_ready stays high with stable line/data until pf_ack or pf_drop.

    pf_state_t    state_q;
    logic         read_q;
    logic         ready_q;
    line_addr_t   fetch_line_q;
    line_addr_t   cline_q;
    logic [255:0] rdata_q;

    line_addr_t miss_line;
    line_addr_t cand_line;
    logic       dup_head;
    logic       dup_flight;
    logic       dup_buf;
    logic       dup_filter;
    logic       cand_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    line_addr_t fifo_head;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^demand_miss_addr[S_OFFSET-1:0];

    assign miss_line  = demand_miss_addr[31:S_OFFSET];
    assign cand_line  = miss_line + line_addr_t'(1);
    assign dup_head   = !fifo_empty && (cand_line == fifo_head);
    assign dup_flight = (state_q == PF_FETCH) && (cand_line == fetch_line_q);
    assign dup_buf    = ready_q && (cand_line == cline_q);
    // The last line has no successor; the address space does not wrap.
    assign cand_push  = demand_miss_valid && (miss_line != '1) &&
                        !dup_head && !dup_flight && !dup_buf && !dup_filter;
    assign fifo_pop   = (state_q == PF_IDLE) && !ready_q && !fifo_empty;

    pf_addr_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (cand_push),
        .push_data_i (cand_line),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

`ifdef PF_FILTER_EN
    localparam int FILT_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

    logic [FILTER_SIZE-1:0] filt_valid_q;
    line_addr_t             filt_addr_q [FILTER_SIZE];
    logic [FILT_W-1:0]      filt_ptr_q;

    always_comb begin
        dup_filter = 1'b0;
        for (int i = 0; i < FILTER_SIZE; i++) begin
            if (filt_valid_q[i] && (filt_addr_q[i] == cand_line)) begin
                dup_filter = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_valid_q <= '0;
            filt_ptr_q   <= '0;
            for (int i = 0; i < FILTER_SIZE; i++) begin
                filt_addr_q[i] <= '0;
            end
        end else if (fifo_pop) begin
            filt_valid_q[filt_ptr_q] <= 1'b1;
            filt_addr_q[filt_ptr_q]  <= fifo_head;
            filt_ptr_q <= (filt_ptr_q == FILT_W'(FILTER_SIZE - 1)) ? '0 : filt_ptr_q + 1'b1;
        end
    end
`else
    logic [31:0] unused_filter_size;
    assign unused_filter_size = FILTER_SIZE;
    assign dup_filter = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PF_IDLE;
            read_q       <= 1'b0;
            ready_q      <= 1'b0;
            fetch_line_q <= '0;
            cline_q      <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                PF_IDLE: begin
                    if (fifo_pop) begin
                        fetch_line_q <= fifo_head;
                        read_q       <= 1'b1;
                        state_q      <= PF_FETCH;
                    end
                end
                PF_FETCH: begin
                    if (pf_pmem_resp) begin
                        rdata_q <= pf_pmem_rdata;
                        cline_q <= fetch_line_q;
                        read_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= PF_HOLD;
                    end
                end
                PF_HOLD: begin
                    if (pf_ack || pf_drop) begin
                        ready_q <= 1'b0;
                        state_q <= PF_IDLE;
                    end
                end
                default: state_q <= PF_IDLE;
            endcase
        end
    end

    assign pf_pmem_read     = read_q;
    assign pf_pmem_address  = line_to_byte(fetch_line_q);
    assign prefetch_ready   = ready_q;
    assign pf_cline_address = line_to_byte(cline_q);
    assign prefetch_rdata   = rdata_q;
    assign dbg_state_o      = state_q;

endmodule
